// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel field types and scheduler state encoding.
package vga_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int MAX_CLIENTS = 4;

  typedef logic [7:0] coord_x_t;
  typedef logic [6:0] coord_y_t;
  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RELEASE,
    ST_DONE
  } sched_state_t;

  // Lowest set bit of mask at or above 'from'; 3'd4 means no client remains.
  function automatic logic [2:0] find_next(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = MAX_CLIENTS - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Scheduler handshake, client pixel streams and shared VGA port.
interface draw_scheduler_if #(
  parameter int N_CLIENTS = 2
);

  logic                     start;
  logic [N_CLIENTS-1:0]     client_en;
  logic                     done;
  logic [N_CLIENTS-1:0]     client_start;
  logic [N_CLIENTS-1:0]     client_done;
  logic [8*N_CLIENTS-1:0]   client_x;
  logic [7*N_CLIENTS-1:0]   client_y;
  logic [3*N_CLIENTS-1:0]   client_colour;
  logic [N_CLIENTS-1:0]     client_plot;
  logic [7:0]               vga_x;
  logic [6:0]               vga_y;
  logic [2:0]               vga_colour;
  logic                     vga_plot;
  logic [14:0]              plot_count;

  modport master (
    output start, client_en, client_done, client_x, client_y, client_colour, client_plot,
    input  done, client_start, vga_x, vga_y, vga_colour, vga_plot, plot_count
  );

  modport slave (
    input  start, client_en, client_done, client_x, client_y, client_colour, client_plot,
    output done, client_start, vga_x, vga_y, vga_colour, vga_plot, plot_count
  );

endinterface

// File: rtl/pixel_clip.sv
// Passes a plot strobe only while active and the pixel lies on screen.
module pixel_clip #(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  vga_pkg::coord_x_t x,
  input  vga_pkg::coord_y_t y,
  input  logic              plot,
  input  logic              active,
  output logic              plot_ok
);
  import vga_pkg::*;

  localparam coord_x_t X_LIM = coord_x_t'(SCREEN_W);
  localparam coord_y_t Y_LIM = coord_y_t'(SCREEN_H);

  assign plot_ok = active && plot && (x < X_LIM) && (y < Y_LIM);

endmodule

// File: rtl/draw_scheduler.sv
// Runs enabled drawing clients in ascending order and muxes the active one onto VGA.
//   state   | meaning
//   IDLE    | waiting for start; latches enable mask on acceptance
//   RUN     | client_start[idx] high, active client owns the VGA port
//   RELEASE | start withdrawn, waiting for client_done[idx] to drop
//   DONE    | done high until start is released
module draw_scheduler #(
  parameter int N_CLIENTS = 2,
  parameter int SCREEN_W  = vga_pkg::SCREEN_W,
  parameter int SCREEN_H  = vga_pkg::SCREEN_H
) (
  input logic             clk,
  input logic             rst_n,
  draw_scheduler_if.slave bus
);
  import vga_pkg::*;

  sched_state_t         state;
  logic [1:0]           idx;
  logic [3:0]           en_q;
  logic [3:0]           en_pad;
  logic [3:0]           scan_mask;
  logic [2:0]           scan_from;
  logic [2:0]           nxt;
  logic [N_CLIENTS-1:0] nxt_start;
  logic [N_CLIENTS-1:0] client_start;
  logic                 done;
  logic [14:0]          plot_count;

  coord_x_t sel_x;
  coord_y_t sel_y;
  colour_t  sel_colour;
  logic     sel_plot;
  logic     sel_done;
  logic     running;
  logic     plot_ok;

  always_comb begin
    en_pad = '0;
    en_pad[N_CLIENTS-1:0] = bus.client_en;
    if (state == ST_IDLE) begin
      scan_mask = en_pad;
      scan_from = 3'd0;
    end else begin
      scan_mask = en_q;
      scan_from = {1'b0, idx} + 3'd1;
    end
    nxt = find_next(scan_mask, scan_from);
    for (int i = 0; i < N_CLIENTS; i++) begin
      nxt_start[i] = (nxt[1:0] == 2'(i));
    end
  end

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_plot   = 1'b0;
    sel_done   = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (idx == 2'(i)) begin
        sel_x      = bus.client_x[i*8 +: 8];
        sel_y      = bus.client_y[i*7 +: 7];
        sel_colour = bus.client_colour[i*3 +: 3];
        sel_plot   = bus.client_plot[i];
        sel_done   = bus.client_done[i];
      end
    end
  end

  assign running = (state == ST_RUN);

  pixel_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .x       (sel_x),
    .y       (sel_y),
    .plot    (sel_plot),
    .active  (running),
    .plot_ok (plot_ok)
  );

  // Coordinates are forced to zero outside RUN so idle clients leave no trace on VGA.
  assign bus.vga_x        = running ? sel_x      : '0;
  assign bus.vga_y        = running ? sel_y      : '0;
  assign bus.vga_colour   = running ? sel_colour : '0;
  assign bus.vga_plot     = plot_ok;
  assign bus.client_start = client_start;
  assign bus.done         = done;
  assign bus.plot_count   = plot_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      en_q         <= '0;
      client_start <= '0;
      done         <= 1'b0;
      plot_count   <= '0;
    end else begin
      if (plot_ok && (plot_count != 15'h7FFF)) plot_count <= plot_count + 15'd1;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            en_q       <= en_pad;
            plot_count <= '0;
            if (nxt[2]) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx          <= nxt[1:0];
              client_start <= nxt_start;
              state        <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (sel_done) begin
            client_start <= '0;
            state        <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!sel_done) begin
            if (nxt[2]) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx          <= nxt[1:0];
              client_start <= nxt_start;
              state        <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          if (!bus.start) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with a pixel scoreboard fed by the client models.
module tb_draw_scheduler;
  import vga_pkg::*;

  localparam int N   = 2;
  localparam int LIM = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  draw_scheduler_if #(.N_CLIENTS(N)) bus ();

  draw_scheduler #(
    .N_CLIENTS (N),
    .SCREEN_W  (160),
    .SCREEN_H  (120)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  int     n_checks = 0;
  int     n_fail = 0;
  int     exp_pixels = 0;
  pix_t   exp_q[$];
  logic   seen_start0 = 1'b0;
  logic [N-1:0] prev_cs = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every VGA plot must match the next scoreboard entry.
  always @(negedge clk) begin
    pix_t e;
    if (bus.vga_plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL vga_unexpected: got (%0d,%0d,%0d), expected no pixel",
                 bus.vga_x, bus.vga_y, bus.vga_colour);
      end else begin
        e = exp_q.pop_front();
        check("vga_pixel", {14'b0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'b0, e});
      end
    end
    if (bus.client_start[0]) seen_start0 = 1'b1;
    if (bus.client_start[1] && !prev_cs[1])
      check("c1_start_after_c0_done_low", {31'b0, bus.client_done[0]}, 32'd0);
    if ((bus.client_start & (bus.client_start - 1'b1)) != '0)
      check("client_start_onehot", {30'b0, bus.client_start}, 32'd0);
    prev_cs = bus.client_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs(input int c, input logic val, input string name);
    int t = 0;
    while (bus.client_start[c] !== val && t < LIM) begin
      tick();
      t++;
    end
    check(name, {31'b0, bus.client_start[c]}, {31'b0, val});
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (bus.done !== 1'b1 && t < LIM) begin
      tick();
      t++;
    end
    check(name, {31'b0, bus.done}, 32'd1);
  endtask

  task automatic drive_pix(input int c, input int x, input int y, input int col);
    if (x < 160 && y < 120) begin
      exp_q.push_back({8'(x), 7'(y), 3'(col)});
      exp_pixels++;
    end
    bus.client_x[c*8 +: 8]      = 8'(x);
    bus.client_y[c*7 +: 7]      = 7'(y);
    bus.client_colour[c*3 +: 3] = 3'(col);
    bus.client_plot[c]          = 1'b1;
    tick();
  endtask

  task automatic finish_client(input int c);
    bus.client_plot[c]          = 1'b0;
    bus.client_x[c*8 +: 8]      = '0;
    bus.client_y[c*7 +: 7]      = '0;
    bus.client_colour[c*3 +: 3] = '0;
    bus.client_done[c]          = 1'b1;
    tick();
    wait_cs(c, 1'b0, "start_drop_on_done");
    bus.client_done[c] = 1'b0;
  endtask

  task automatic circle(input int c);
    int x = 0;
    int y = 40;
    int d = 1 - 40;
    while (y >= x) begin
      drive_pix(c, 80 + x, 60 + y, 2);
      drive_pix(c, 80 - x, 60 + y, 2);
      drive_pix(c, 80 + x, 60 - y, 2);
      drive_pix(c, 80 - x, 60 - y, 2);
      drive_pix(c, 80 + y, 60 + x, 2);
      drive_pix(c, 80 - y, 60 + x, 2);
      drive_pix(c, 80 + y, 60 - x, 2);
      drive_pix(c, 80 - y, 60 - x, 2);
      x++;
      if (d < 0) d += 2 * x + 1;
      else begin
        y--;
        d += 2 * (x - y) + 1;
      end
    end
  endtask

  task automatic background0(input logic on);
    bus.client_x[7:0]      = on ? 8'd5 : 8'd0;
    bus.client_y[6:0]      = on ? 7'd5 : 7'd0;
    bus.client_colour[2:0] = on ? 3'd7 : 3'd0;
    bus.client_plot[0]     = on;
  endtask

  task automatic start_seq(input logic [N-1:0] en);
    exp_pixels    = 0;
    bus.client_en = en;
    bus.start     = 1'b1;
  endtask

  task automatic end_seq();
    bus.start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start         = 1'b0;
    bus.client_en     = '0;
    bus.client_done   = '0;
    bus.client_x      = '0;
    bus.client_y      = '0;
    bus.client_colour = '0;
    bus.client_plot   = '0;
    tick();
    tick();
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_client_start", {30'b0, bus.client_start}, 32'd0);
    check("rst_plot_count", {17'b0, bus.plot_count}, 32'd0);
    check("rst_vga_plot", {31'b0, bus.vga_plot}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset asserted in the middle of client 0's run.
    start_seq(2'b01);
    wait_cs(0, 1'b1, "rst_test_c0_start");
    drive_pix(0, 1, 1, 7);
    drive_pix(0, 2, 1, 7);
    drive_pix(0, 3, 1, 7);
    bus.client_x[7:0]  = 8'd10;
    bus.client_y[6:0]  = 7'd10;
    bus.client_plot[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_client_start", {30'b0, bus.client_start}, 32'd0);
    check("midrun_rst_vga_plot", {31'b0, bus.vga_plot}, 32'd0);
    check("midrun_rst_plot_count", {17'b0, bus.plot_count}, 32'd0);
    check("midrun_rst_vga_x", {24'b0, bus.vga_x}, 32'd0);
    check("midrun_rst_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
    bus.start          = 1'b0;
    bus.client_plot[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Full sequence: screen fill by client 0, then circle by client 1.
    start_seq(2'b11);
    wait_cs(0, 1'b1, "full_c0_start");
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        drive_pix(0, x, y, 0);
    finish_client(0);
    check("full_fill_pixels", exp_pixels, 32'd19200);
    background0(1'b1);
    wait_cs(1, 1'b1, "full_c1_start");
    circle(1);
    finish_client(1);
    background0(1'b0);
    wait_done("full_done");
    check("full_plot_count", {17'b0, bus.plot_count}, exp_pixels);
    end_seq();
    check("full_done_release", {31'b0, bus.done}, 32'd0);

    // Clipping of off-screen pixels.
    start_seq(2'b01);
    wait_cs(0, 1'b1, "clip_c0_start");
    drive_pix(0, 160, 0, 1);
    drive_pix(0, 0, 120, 2);
    drive_pix(0, 159, 119, 3);
    finish_client(0);
    wait_done("clip_done");
    check("clip_plot_count", {17'b0, bus.plot_count}, 32'd1);
    end_seq();

    // Client 0 disabled but plotting at (5,5) the whole time.
    seen_start0 = 1'b0;
    background0(1'b1);
    start_seq(2'b10);
    wait_cs(1, 1'b1, "mask_c1_start");
    drive_pix(1, 3, 4, 5);
    drive_pix(1, 159, 0, 6);
    finish_client(1);
    wait_done("mask_done");
    check("mask_c0_never_started", {31'b0, seen_start0}, 32'd0);
    check("mask_plot_count", {17'b0, bus.plot_count}, 32'd2);
    background0(1'b0);
    end_seq();

    // Empty mask finishes without running anyone.
    start_seq(2'b00);
    tick();
    if (bus.done !== 1'b1) tick();
    check("empty_done_2cyc", {31'b0, bus.done}, 32'd1);
    check("empty_plot_count", {17'b0, bus.plot_count}, 32'd0);
    check("empty_client_start", {30'b0, bus.client_start}, 32'd0);
    end_seq();

    // Pre-asserted client_done: one-cycle RUN, RELEASE holds until done drops.
    bus.client_done[0] = 1'b1;
    start_seq(2'b01);
    wait_cs(0, 1'b1, "hs_c0_start");
    check("hs_run_state", {30'b0, dut.state}, {30'b0, ST_RUN});
    tick();
    check("hs_run_one_cycle", {30'b0, bus.client_start}, 32'd0);
    tick();
    tick();
    tick();
    check("hs_release_hold", {30'b0, dut.state}, {30'b0, ST_RELEASE});
    check("hs_release_no_done", {31'b0, bus.done}, 32'd0);
    bus.client_done[0] = 1'b0;
    tick();
    check("hs_done_set", {31'b0, bus.done}, 32'd1);
    tick();
    check("hs_done_held_with_start", {31'b0, bus.done}, 32'd1);
    bus.start = 1'b0;
    tick();
    check("hs_done_clear", {31'b0, bus.done}, 32'd0);
    check("hs_idle", {30'b0, dut.state}, {30'b0, ST_IDLE});

    // start dropped mid-sequence: completes, done pulses once.
    start_seq(2'b01);
    wait_cs(0, 1'b1, "early_c0_start");
    bus.start = 1'b0;
    drive_pix(0, 20, 30, 4);
    finish_client(0);
    tick();
    check("early_done_pulse", {31'b0, bus.done}, 32'd1);
    tick();
    check("early_done_gone", {31'b0, bus.done}, 32'd0);
    check("early_idle", {30'b0, dut.state}, {30'b0, ST_IDLE});
    tick();
    check("early_count_hold", {17'b0, bus.plot_count}, 32'd1);

    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter N_CLIENTS, default 2, number of drawing engines sequenced (range 1..4).
REQ-002 Parameter SCREEN_W, default 160, visible width in pixels.
REQ-003 Parameter SCREEN_H, default 120, visible height in pixels.
REQ-004 clk  in  1  system clock (CLOCK_50); all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset (driven from KEY[3]).
REQ-006 start  in  1  request to run the enabled client sequence; held high until done seen.
REQ-007 client_en  in  N_CLIENTS  per-client enable mask, sampled when start is accepted.
REQ-008 done  out  1  sequence complete; held high until start deasserts.
REQ-009 client_start  out  N_CLIENTS  one-hot start to the active client.
REQ-010 client_done  in  N_CLIENTS  per-client done, same hold-until-start-low handshake.
REQ-011 client_x  in  8*N_CLIENTS, client_y  in  7*N_CLIENTS, client_colour  in  3*N_CLIENTS, client_plot  in  N_CLIENTS  pixel streams.
REQ-012 vga_x  out  8, vga_y  out  7, vga_colour  out  3, vga_plot  out  1  shared VGA adapter port.
REQ-013 plot_count  out  15  pixels written in current/last sequence.

Function
REQ-014 FSM states SHALL be IDLE, RUN, RELEASE, DONE.
REQ-015 IDLE: on start=1, latch client_en, clear plot_count, set idx to lowest enabled client, go RUN; if mask is zero go DONE directly.
REQ-016 RUN: client_start[idx]=1; on client_done[idx]=1 go RELEASE next cycle.
REQ-017 RELEASE: client_start all 0; when client_done[idx]=0, advance idx to next enabled client and go RUN, or go DONE if none remain.
REQ-018 DONE: done=1; on start=0 go IDLE next cycle.
REQ-019 Clients SHALL run strictly in ascending index order; disabled clients never receive start.
REQ-020 vga_x/vga_y/vga_colour SHALL combinationally mirror client idx (zero latency); vga_plot = client_plot[idx] AND state==RUN AND x<SCREEN_W AND y<SCREEN_H.
REQ-021 Outside RUN, vga_plot SHALL be 0 and vga_x/vga_y/vga_colour SHALL be 0; client_plot from non-active clients is ignored.
REQ-022 Out-of-range pixels (x>=160 or y>=120) SHALL be dropped silently and not counted.
REQ-023 plot_count SHALL increment by 1 per cycle with vga_plot=1, saturate at 0x7FFF, and hold after DONE until next accepted start.
REQ-024 start dropping during RUN/RELEASE SHALL NOT abort; sequence completes, then DONE exits immediately if start is low.
REQ-025 client_done already high on entry to RUN SHALL be treated as completion (RUN lasts one cycle).
REQ-026 client_en changes after acceptance SHALL have no effect until the next sequence.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, idx=0, done=0, client_start=0, vga_plot=0, vga_x/y/colour=0, plot_count=0, including mid-sequence.
REQ-028 First start acceptance SHALL occur no earlier than the first rising edge after rst_n rises.

Structure
REQ-029 Shared package vga_pkg SHALL hold SCREEN_W/SCREEN_H constants, coordinate/colour typedefs (8/7/3 bit) and the scheduler state enum.
REQ-030 One sub-module, pixel_clip (range check + gating), is natural; the FSM and mux stay in draw_scheduler.

Verification
REQ-031 Reset: rst_n=0 mid-RUN of client 0 -> next sample: client_start=0, vga_plot=0, plot_count=0, state IDLE.
REQ-032 Full sequence: en=2'b11, client 0 model fills 160x120 black, client 1 plots 8-octant circle centre (80,60) r=40 green -> client 1 start only after client 0 done low; done=1; plot_count=19200+circle pixel count.
REQ-033 Clipping: client plots (160,0), (0,120), (159,119) -> only (159,119) reaches vga_plot; plot_count=1.
REQ-034 Masking: en=2'b10 -> client_start[0] never high; first vga pixel from client 1; en=2'b00 -> done within 2 cycles of start, plot_count=0.
REQ-035 Handshake: client_done pre-asserted high, start held -> RUN one cycle, RELEASE holds until done low; start low before sequence end -> done pulses one cycle then IDLE.
REQ-036 Isolation: non-active client drives plot=1 at (5,5) throughout -> never visible on vga port.
